// File: rtl/mult_div_sequencer_if.sv
// mult_div_sequencer_if: bundle of the EX-side signals of the HI/LO
// multiply/divide sequencer.
//   op_valid, op_code, operand_a, operand_b, hilo_read : EX -> sequencer
//   hi, lo, busy, mult_div_stall                      : sequencer -> EX/stall unit
// master = EX stage side, slave = the sequencer itself.
interface mult_div_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             hilo_read;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             mult_div_stall;

  modport master (
    output op_valid, op_code, operand_a, operand_b, hilo_read,
    input  hi, lo, busy, mult_div_stall
  );

  modport slave (
    input  op_valid, op_code, operand_a, operand_b, hilo_read,
    output hi, lo, busy, mult_div_stall
  );
endinterface

// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative multiply/divide unit owning the HI/LO pair.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs a one-bit-per-cycle
// shift-add multiplier or restoring divider on operand magnitudes, applies
// signs in a final FIX cycle and writes HI/LO. Requests a pipeline stall
// while busy if EX presents another HI/LO op or an MFHI/MFLO read.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult_div_sequencer_if.slave (operation inputs, hi/lo/busy/stall)
module mult_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_div_sequencer_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Magnitude of a value when it is to be treated as negative.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic neg);
    magnitude = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Conditional two's-complement negate of a WIDTH-bit result.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    apply_sign = neg ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  // Conditional two's-complement negate of the double-width product.
  function automatic logic [2*WIDTH-1:0] apply_sign_wide(input logic [2*WIDTH-1:0] x,
                                                         input logic neg);
    apply_sign_wide = neg ? (~x + {{(2*WIDTH-1){1'b0}}, 1'b1}) : x;
  endfunction

  state_t             state;
  logic [CW-1:0]      cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {remainder, dividend bits not yet consumed / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   a_raw;     // dividend as presented, for divide-by-zero HI
  logic               is_div;
  logic               neg_q;     // sign of product / quotient
  logic               neg_r;     // sign of remainder
  logic               div_zero;
  logic [WIDTH-1:0]   hi_val;
  logic [WIDTH-1:0]   lo_val;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] mul_step;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Sign extraction only applies to the signed codes (bit 0 clear).
  assign a_neg = ~bus.op_code[0] & bus.operand_a[WIDTH-1];
  assign b_neg = ~bus.op_code[0] & bus.operand_b[WIDTH-1];
  assign a_mag = magnitude(bus.operand_a, a_neg);
  assign b_mag = magnitude(bus.operand_b, b_neg);

  // One shift-add step: add multiplicand on multiplier LSB, keep carry, shift right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

  // One restoring step; the extra top bit keeps full-width divisors exact.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

  assign product = apply_sign_wide(acc, neg_q);

  // Final HI/LO values written at the FIX edge.
  always_comb begin
    fix_hi = product[2*WIDTH-1:WIDTH];
    fix_lo = product[WIDTH-1:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = a_raw;
        fix_lo = '1;
      end else begin
        fix_hi = apply_sign(acc[2*WIDTH-1:WIDTH], neg_r);
        fix_lo = apply_sign(acc[WIDTH-1:0], neg_q);
      end
    end else begin
      fix_hi = product[2*WIDTH-1:WIDTH];
      fix_lo = product[WIDTH-1:0];
    end
  end

  // Sequencer FSM, working registers and architectural HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_val   <= '0;
      lo_val   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            case (bus.op_code)
              OP_MULT, OP_MULTU: begin
                state    <= RUN;
                cnt      <= '0;
                is_div   <= 1'b0;
                acc      <= {{WIDTH{1'b0}}, b_mag};
                opnd     <= a_mag;
                a_raw    <= bus.operand_a;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= 1'b0;
                div_zero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                state    <= RUN;
                cnt      <= '0;
                is_div   <= 1'b1;
                acc      <= {{WIDTH{1'b0}}, a_mag};
                opnd     <= b_mag;
                a_raw    <= bus.operand_a;
                neg_q    <= a_neg ^ b_neg;
                neg_r    <= a_neg;
                div_zero <= (bus.operand_b == {WIDTH{1'b0}});
              end
              OP_MTHI: hi_val <= bus.operand_a;
              OP_MTLO: lo_val <= bus.operand_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          acc <= is_div ? div_step : mul_step;
          cnt <= cnt + CW'(1);
          if (cnt == LAST_ITER) begin
            state <= FIX;
          end
        end
        FIX: begin
          hi_val <= fix_hi;
          lo_val <= fix_lo;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.hi             = hi_val;
  assign bus.lo             = lo_val;
  assign bus.busy           = (state != IDLE);
  assign bus.mult_div_stall = bus.busy & (bus.op_valid | bus.hilo_read);

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer (WIDTH=32): table of vectors
// plus model-derived random vectors, scoreboard of expected HI/LO popped on
// completion, and hand sequences for reset, stall, back-to-back and MTHI/MTLO.
module tb_mult_div_sequencer;
  localparam int W = 32;

  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_div_sequencer_if #(.WIDTH(W)) bus ();

  mult_div_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           due;
  } exp_t;

  exp_t sb[$];
  vec_t tv[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic prev_busy = 1'b0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference for random vectors.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb_, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sb_ = longint'($signed(b));
    p   = 64'd0;
    case (op)
      3'd0: p = 64'(sa * sb_);
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_;
          r = sa % sb_;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Completion monitor: busy falling marks the first cycle HI/LO are valid.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy <= 1'b0;
    end else begin
      if (prev_busy && !bus.busy) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: completion at cycle %0d with empty scoreboard", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", {bus.hi, bus.lo}, {e.hi, e.lo});
          chk("latency", 64'(cyc), 64'(e.due));
        end
      end
      prev_busy <= bus.busy;
    end
  end

  // Present an op (called at a negedge), hold through stall, return at the
  // negedge after the accept edge with that cycle number.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [63:0] exp, output int acc_cyc);
    int budget;
    bus.op_valid  = 1'b1;
    bus.op_code   = op;
    bus.operand_a = a;
    bus.operand_b = b;
    #1;
    budget = 0;
    while (bus.mult_div_stall && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (budget >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: stall still %0b after %0d cycles", bus.mult_div_stall, budget);
    end
    @(negedge clk);
    acc_cyc = cyc;
    sb.push_back('{exp[63:32], exp[31:0], cyc + W + 1});
    bus.op_valid  = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 60) begin
      @(negedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int acc1;
    int acc2;
    int bad;
    logic [63:0] prev_hilo;
    logic [2:0]  rop;
    logic [W-1:0] ra, rb;

    tv.push_back('{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    tv.push_back('{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA});
    tv.push_back('{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    tv.push_back('{3'd3, 32'd100,       32'd7,         32'd2,         32'd14});
    tv.push_back('{3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF});
    tv.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000});
    tv.push_back('{3'd2, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF});
    tv.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD});
    tv.push_back('{3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000});
    tv.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    tv.push_back('{3'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001});

    // Reset with operations pending on the inputs.
    rst_n         = 1'b0;
    bus.op_valid  = 1'b1;
    bus.op_code   = 3'd0;
    bus.operand_a = 32'h1234_5678;
    bus.operand_b = 32'h0000_0009;
    bus.hilo_read = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("reset_busy_stall", {62'd0, bus.busy, bus.mult_div_stall}, 64'd0);
    bus.op_valid  = 1'b0;
    bus.hilo_read = 1'b0;
    rst_n         = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {63'd0, bus.busy}, 64'd0);

    // Reset pulse in the middle of RUN aborts with no HI/LO update.
    issue(3'd0, 32'd5, 32'd7, 64'd35, acc1);
    repeat (10) @(negedge clk);
    chk("run_busy", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #2;
    chk("midrun_reset_busy", {63'd0, bus.busy}, 64'd0);
    sb.delete();
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrun_reset_idle", {63'd0, bus.busy}, 64'd0);

    // Directed table.
    for (int i = 0; i < tv.size(); i++) begin
      issue(tv[i].op, tv[i].a, tv[i].b, {tv[i].hi, tv[i].lo}, acc1);
      wait_idle();
    end

    // Random vectors against the reference model.
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : $urandom;
      issue(rop, ra, rb, model(rop, ra, rb), acc1);
      wait_idle();
    end

    // MFHI/MFLO during a MULT: stall cycles 5..33, released at 34.
    prev_hilo = {bus.hi, bus.lo};
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, acc1);
    repeat (4) @(negedge clk);
    bus.hilo_read = 1'b1;
    #1;
    bad = 0;
    for (int c = 5; c <= 33; c++) begin
      if (!bus.mult_div_stall || ({bus.hi, bus.lo} !== prev_hilo)) bad++;
      @(negedge clk);
      #1;
    end
    chk("stall_window_bad_cycles", 64'(bad), 64'd0);
    chk("stall_release", {63'd0, bus.mult_div_stall}, 64'd0);
    chk("read_after_stall", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    bus.hilo_read = 1'b0;
    wait_idle();

    // Back-to-back: second op held during busy, accepted with no bubble.
    issue(3'd1, 32'd3, 32'd4, 64'h0000_0000_0000_000C, acc1);
    issue(3'd3, 32'd9, 32'd2, 64'h0000_0001_0000_0004, acc2);
    chk("b2b_accept_gap", 64'(acc2 - acc1), 64'(W + 2));
    wait_idle();
    chk("b2b_final", {bus.hi, bus.lo}, 64'h0000_0001_0000_0004);

    // MTHI then MTLO in consecutive idle cycles, then a reserved code.
    bus.op_valid  = 1'b1;
    bus.op_code   = 3'd4;
    bus.operand_a = 32'hDEAD_BEEF;
    #1;
    chk("mthi_no_stall", {63'd0, bus.mult_div_stall}, 64'd0);
    @(negedge clk);
    chk("mthi_value", {32'd0, bus.hi}, {32'd0, 32'hDEAD_BEEF});
    bus.op_code   = 3'd5;
    bus.operand_a = 32'h1234_5678;
    #1;
    chk("mtlo_no_stall", {63'd0, bus.mult_div_stall}, 64'd0);
    @(negedge clk);
    chk("mtlo_value", {bus.hi, bus.lo}, 64'hDEAD_BEEF_1234_5678);
    bus.op_code   = 3'd6;
    bus.operand_a = 32'h0000_0000;
    @(negedge clk);
    bus.op_code   = 3'd7;
    @(negedge clk);
    chk("reserved_noop", {bus.hi, bus.lo}, 64'hDEAD_BEEF_1234_5678);
    chk("reserved_idle", {63'd0, bus.busy}, 64'd0);
    bus.op_valid  = 1'b0;
    bus.hilo_read = 1'b1;
    #1;
    chk("idle_read_no_stall", {63'd0, bus.mult_div_stall}, 64'd0);
    bus.hilo_read = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
